// File: rtl/sar_threshold_search_pkg.sv
// Shared definitions for the successive-approximation threshold search:
// state encoding and the default code width / verdict timeout.
package sar_threshold_search_pkg;

  // Code width, shared with the three cascaded 3-bit comparator slices.
  localparam int SAR_W       = 9;
  localparam int SAR_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRIAL = 2'd1,
    ST_DONE  = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_timeout_counter.sv
// Counts trial cycles spent waiting for a comparator verdict.
// expired_o flags that one more waiting cycle reaches TIMEOUT.
module sar_timeout_counter #(
  parameter int TIMEOUT = 255,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/sar_threshold_search.sv
// Successive-approximation controller: issues MSB-first trial codes to the
// comparator chain and converges on the measured value from L/E/G verdicts.
module sar_threshold_search
  import sar_threshold_search_pkg::*;
#(
  parameter int W       = SAR_W,
  parameter int TIMEOUT = SAR_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] trial,
  output logic         trial_valid,
  input  logic         cmp_valid,
  input  logic         cmp_lt,
  input  logic         cmp_eq,
  input  logic         cmp_gt,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         exact,
  output logic         error,
  output logic [1:0]   dbg_state
);

  localparam int            KW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(W - 1);
  localparam logic [W-1:0]  ONE   = W'(1);

  // Handshake: trial is held stable while trial_valid=1; a verdict is
  // consumed only on a rising edge where cmp_valid=1, otherwise cmp_* are
  // ignored. A new trial (or the end of the search) follows every accepted
  // verdict on the next cycle.
  sar_state_e    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  trial_q, trial_d;
  logic [W-1:0]  result_q, result_d;
  logic [KW-1:0] k_q, k_d;
  logic          trial_valid_q, trial_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          exact_q, exact_d;
  logic          error_q, error_d;

  logic          cnt_clear, cnt_inc, cnt_expired;
  logic          v_eq, v_gt, v_bad, fin;
  logic [W-1:0]  acc_new;

  sar_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (cnt_clear),
    .inc_i     (cnt_inc),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    trial_d       = trial_q;
    result_d      = result_q;
    k_d           = k_q;
    trial_valid_d = trial_valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    exact_d       = exact_q;
    error_d       = error_q;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;
    v_eq          = 1'b0;
    v_gt          = 1'b0;
    v_bad         = 1'b0;
    fin           = 1'b0;
    acc_new       = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d         = '0;
          k_d           = K_TOP;
          trial_d       = ONE << K_TOP;
          trial_valid_d = 1'b1;
          busy_d        = 1'b1;
          result_d      = '0;
          exact_d       = 1'b0;
          error_d       = 1'b0;
          cnt_clear     = 1'b1;
          state_d       = ST_TRIAL;
        end
      end

      ST_TRIAL: begin
        if (cmp_valid) begin
          cnt_clear = 1'b1;
          // Exactly one verdict line must be high; anything else aborts.
          case ({cmp_lt, cmp_eq, cmp_gt})
            3'b100:  begin end
            3'b010:  v_eq  = 1'b1;
            3'b001:  v_gt  = 1'b1;
            default: v_bad = 1'b1;
          endcase
          acc_new = v_gt ? (acc_q | (ONE << k_q)) : acc_q;
          if (v_bad) begin
            fin      = 1'b1;
            result_d = acc_q;
            exact_d  = 1'b0;
            error_d  = 1'b1;
          end else if (v_eq) begin
            fin      = 1'b1;
            result_d = trial_q;
            exact_d  = 1'b1;
          end else if (k_q == '0) begin
            fin      = 1'b1;
            result_d = acc_new;
            exact_d  = 1'b0;
          end else begin
            acc_d   = acc_new;
            k_d     = k_q - 1'b1;
            trial_d = acc_new | (ONE << (k_q - 1'b1));
          end
        end else if (cnt_expired) begin
          fin      = 1'b1;
          result_d = acc_q;
          exact_d  = 1'b0;
          error_d  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      state_d       = ST_DONE;
      done_d        = 1'b1;
      trial_valid_d = 1'b0;
      busy_d        = 1'b0;
      trial_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      trial_q       <= '0;
      result_q      <= '0;
      k_q           <= K_TOP;
      trial_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      exact_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      trial_q       <= trial_d;
      result_q      <= result_d;
      k_q           <= k_d;
      trial_valid_q <= trial_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      exact_q       <= exact_d;
      error_q       <= error_d;
    end
  end

  assign trial       = trial_q;
  assign trial_valid = trial_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign exact       = exact_q;
  assign error       = error_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sar_threshold_search.sv
// Directed bench for sar_threshold_search with a behavioural comparator
// responder (configurable delay, malformed verdict, silence).
module tb_sar_threshold_search;

  localparam int W = 9;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] trial;
  logic         trial_valid;
  logic         cmp_valid, cmp_lt, cmp_eq, cmp_gt;
  logic         busy, done, exact, error;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  logic [W-1:0] measured;
  int           delay;
  logic         silent;
  logic         malformed;

  int           checks;
  int           errors;

  int           age;
  logic         prev_valid;
  logic [W-1:0] prev_trial;
  logic         prev_acc;
  int           stab_viol;
  logic [W-1:0] seen_q[$];
  logic [W-1:0] exp_q[$];

  sar_threshold_search dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .trial       (trial),
    .trial_valid (trial_valid),
    .cmp_valid   (cmp_valid),
    .cmp_lt      (cmp_lt),
    .cmp_eq      (cmp_eq),
    .cmp_gt      (cmp_gt),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .exact       (exact),
    .error       (error),
    .dbg_state   (dbg_state)
  );

  // clock / reset-independent clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural comparator: answers once the trial has been stable for
  // 'delay' cycles.
  assign cmp_valid = trial_valid && !silent && (age >= delay);
  assign cmp_lt    = malformed ? 1'b1 : (measured < trial);
  assign cmp_eq    = malformed ? 1'b0 : (measured == trial);
  assign cmp_gt    = malformed ? 1'b1 : (measured > trial);

  // Responder state, trial log and trial-stability monitor.
  always @(negedge clk) begin
    int   nage;
    logic acc;
    nage = (trial_valid && prev_valid && trial == prev_trial) ? age + 1 : 0;
    acc  = trial_valid && !silent && (nage >= delay);
    if (prev_valid && trial_valid && !prev_acc && trial != prev_trial)
      stab_viol <= stab_viol + 1;
    if (acc) seen_q.push_back(trial);
    age        <= nage;
    prev_valid <= trial_valid;
    prev_trial <= trial;
    prev_acc   <= acc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_trials(input string tag);
    check({tag, "_ntrials"}, 32'(seen_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < seen_q.size())
        check($sformatf("%s_trial%0d", tag, i), 32'(seen_q[i]), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  // Pulses start, optionally re-pulses it mid-search, waits (bounded) for done.
  task automatic run_search(input bit poke, output int cyc, output bit timed_out);
    seen_q.delete();
    cyc       = 0;
    timed_out = 1'b1;
    start     = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 3 || cyc == 10 || cyc == 21);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    bit to;
    int done_seen;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    measured   = '0;
    delay      = 0;
    silent     = 1'b0;
    malformed  = 1'b0;
    age        = 0;
    prev_valid = 1'b0;
    prev_trial = '0;
    prev_acc   = 1'b0;
    stab_viol  = 0;

    repeat (3) @(negedge clk);
    check("rst_trial",       32'(trial), 0);
    check("rst_trial_valid", 32'(trial_valid), 0);
    check("rst_busy",        32'(busy), 0);
    check("rst_done",        32'(done), 0);
    check("rst_result",      32'(result), 0);
    check("rst_exact",       32'(exact), 0);
    check("rst_error",       32'(error), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // measured = 300, zero-wait responder
    measured = 9'd300;
    run_search(1'b0, cyc, to);
    check("m300_timeout", 32'(to), 0);
    check("m300_cycles",  32'(cyc), 8);
    check("m300_result",  32'(result), 300);
    check("m300_exact",   32'(exact), 1);
    check("m300_error",   32'(error), 0);
    exp_q = '{9'd256, 9'd384, 9'd320, 9'd288, 9'd304, 9'd296, 9'd300};
    compare_trials("m300");
    @(negedge clk);
    check("m300_done_pulse", 32'(done), 0);
    check("m300_busy_after", 32'(busy), 0);
    check("m300_state_idle", 32'(dbg_state), 0);
    check("m300_result_held", 32'(result), 300);

    // measured = 0: nine lt verdicts
    measured = 9'd0;
    run_search(1'b0, cyc, to);
    check("m0_timeout", 32'(to), 0);
    check("m0_cycles",  32'(cyc), 10);
    check("m0_result",  32'(result), 0);
    check("m0_exact",   32'(exact), 0);
    check("m0_error",   32'(error), 0);
    exp_q = '{9'd256, 9'd128, 9'd64, 9'd32, 9'd16, 9'd8, 9'd4, 9'd2, 9'd1};
    compare_trials("m0");
    @(negedge clk);

    // measured = 511: climbs to the top code, ends on equality
    measured = 9'd511;
    run_search(1'b0, cyc, to);
    check("m511_timeout", 32'(to), 0);
    check("m511_cycles",  32'(cyc), 10);
    check("m511_result",  32'(result), 511);
    check("m511_exact",   32'(exact), 1);
    exp_q = '{9'd256, 9'd384, 9'd448, 9'd480, 9'd496, 9'd504, 9'd508, 9'd510, 9'd511};
    compare_trials("m511");
    @(negedge clk);

    // measured = 5, 3-cycle verdict delay, start re-pulsed mid-search
    measured  = 9'd5;
    delay     = 3;
    stab_viol = 0;
    run_search(1'b1, cyc, to);
    check("m5_timeout", 32'(to), 0);
    check("m5_cycles",  32'(cyc), 37);
    check("m5_result",  32'(result), 5);
    check("m5_exact",   32'(exact), 1);
    check("m5_stable",  32'(stab_viol), 0);
    exp_q = '{9'd256, 9'd128, 9'd64, 9'd32, 9'd16, 9'd8, 9'd4, 9'd6, 9'd5};
    compare_trials("m5");
    start = 1'b1;              // start during the done pulse is ignored
    @(negedge clk);
    start = 1'b0;
    check("m5_start_on_done_busy",  32'(busy), 0);
    check("m5_start_on_done_valid", 32'(trial_valid), 0);
    @(negedge clk);
    check("m5_start_on_done_idle", 32'(dbg_state), 0);
    delay = 0;

    // lt and gt asserted together on the first verdict
    malformed = 1'b1;
    run_search(1'b0, cyc, to);
    check("bad_timeout", 32'(to), 0);
    check("bad_cycles",  32'(cyc), 2);
    check("bad_error",   32'(error), 1);
    check("bad_result",  32'(result), 0);
    check("bad_exact",   32'(exact), 0);
    malformed = 1'b0;
    @(negedge clk);

    // no verdict at all: timeout abort
    silent = 1'b1;
    run_search(1'b0, cyc, to);
    check("tmo_timeout", 32'(to), 0);
    check("tmo_cycles",  32'(cyc), 256);
    check("tmo_error",   32'(error), 1);
    check("tmo_exact",   32'(exact), 0);
    silent = 1'b0;
    @(negedge clk);

    // reset during the fourth trial of a search for 77
    measured = 9'd77;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst4_trial_before", 32'(trial), 96);
    rst_n = 1'b0;
    #1;
    check("rst4_trial",       32'(trial), 0);
    check("rst4_trial_valid", 32'(trial_valid), 0);
    check("rst4_busy",        32'(busy), 0);
    check("rst4_result",      32'(result), 0);
    check("rst4_error",       32'(error), 0);
    check("rst4_done",        32'(done), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rst4_no_done", 32'(done_seen), 0);
    run_search(1'b0, cyc, to);
    check("m77_timeout", 32'(to), 0);
    check("m77_cycles",  32'(cyc), 10);
    check("m77_result",  32'(result), 77);
    check("m77_exact",   32'(exact), 1);
    check("m77_error",   32'(error), 0);
    exp_q = '{9'd256, 9'd128, 9'd64, 9'd96, 9'd80, 9'd72, 9'd76, 9'd78, 9'd77};
    compare_trials("m77");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_threshold_search.md
Name: sar_threshold_search

Overview:
- Successive-approximation controller that drives the magnitude-comparator chain and consumes its L/E/G verdicts.
- It produces trial codes MSB-first. From each verdict it decides whether to keep the trial bit, and it converges on the measured vital-sign value held on the comparator's other operand.
- It sits between the sensor-sample register and the alarm/threshold logic of the health-care datapath. It is the initiator of the comparison protocol; the comparator chain is the responder.

Parameters:
- W, 9, width of the trial code and result (three cascaded 3-bit comparator slices).
- TIMEOUT, 255, maximum cycles to wait for a comparator verdict before aborting; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a search; honoured only in IDLE.
- trial  out  W  current trial code driven to comparator operand B.
- trial_valid  out  1  trial is stable and a verdict is requested.
- cmp_valid  in  1  comparator verdict valid this cycle.
- cmp_lt  in  1  measured value < trial.
- cmp_eq  in  1  measured value == trial.
- cmp_gt  in  1  measured value > trial.
- busy  out  1  search in progress.
- done  out  1  single-cycle pulse; result, exact and error are valid.
- result  out  W  converged value; held until the next start.
- exact  out  1  search ended on an equality verdict.
- error  out  1  search aborted (malformed verdict or timeout).

Behaviour:
- Reset (async, rst_n=0): state=IDLE. trial=0, trial_valid=0, busy=0, done=0, result=0, exact=0, error=0. Bit index=W-1, timeout counter=0.
- Reset mid-search: the search is abandoned immediately. No done pulse is issued after release.
- States: IDLE, TRIAL, DONE.
- IDLE, start=1:
  - acc=0, k=W-1.
  - trial=1<<(W-1), trial_valid=1, busy=1.
  - exact, error and result are cleared.
  - Next state TRIAL.
- TRIAL:
  - trial = acc | (1<<k), held stable while trial_valid=1.
  - The verdict is sampled only on a cycle with cmp_valid=1. cmp_* are ignored otherwise.
- Valid verdict check: exactly one of lt/eq/gt must be high. Zero or multiple high gives error=1, result=acc, exact=0, go to DONE.
- Verdict gt: acc |= (1<<k).
- Verdict lt: bit k stays 0.
- Verdict eq: result=trial, exact=1, go to DONE (early termination).
- After a gt or lt verdict with k=0: result=updated acc, exact=0, go to DONE.
- After a gt or lt verdict with k>0: k decrements. The next trial appears on the following cycle. trial_valid remains 1; the comparator observes the new value on the same edge.
- Timeout:
  - The counter increments each TRIAL cycle without cmp_valid.
  - It resets to 0 on every accepted verdict.
  - Reaching TIMEOUT gives error=1, result=acc, go to DONE.
- DONE:
  - done=1 for exactly one cycle, trial_valid=0, busy=0.
  - Next state IDLE; result, exact and error stay held.
- start while busy or in DONE: ignored, with no effect on the current search.
- start in the same cycle as the done pulse: ignored. A new search needs start in IDLE.
- Latency with a 0-wait comparator: trial count + 1 cycles from start to done. The maximum is W trials.
- Arithmetic: all unsigned, W bits, no overflow possible (acc ≤ 2^W−1).
- Outputs are registered; cmp_* need no combinational path to the outputs.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE/TRIAL/DONE);
  - the default W=9 constant, shared with the comparator-chain width;
  - the default TIMEOUT constant.
- One natural sub-module: sar_timeout_counter (load/clear/increment, expired flag).
- The verdict-decode/check logic stays inline.

Test Plan:
- W=9, measured=300, 0-wait responder:
  - trials 256(gt), 384(lt), 320(lt), 288(gt), 304(lt), 296(gt), 300(eq);
  - done at cycle 8 after start, result=300, exact=1, error=0.
- Measured=0: nine lt verdicts, trials 256, 128, …, 1 → result=0, exact=0, done after 10 cycles.
- Measured=511: trials 256, 384, 448, 480, 496, 504, 508, 510, 511(eq) → result=511, exact=1.
- Responder with 3-cycle verdict delay and measured=5:
  - trial is held stable while waiting;
  - result=5, exact=1;
  - start pulses mid-search are ignored.
- Responder asserts lt and gt together on the first verdict → done with error=1, result=0. Separately, no cmp_valid for 255 cycles → error=1 timeout.
- rst_n asserted during trial 4 → all outputs 0 immediately. After release, no done pulse; a fresh start with measured=77 converges to result=77.
